post_add_acc: RTL and testbench

Post-adder/accumulator stage that consumes the 48-bit multiplier-stage output (the M-stage mux output) and produces the block's P result.
- Selects X and Z operands under OPMODE control, adds or subtracts them with a carry-in, and holds the result in an optional P register.
- The P register doubles as the accumulator through the P feedback path.
- Drives P, PCOUT (cascade) and CARRYOUT; sits directly downstream of the M register in the DSP slice datapath.

---
 rtl/dsp_pkg.sv | 37 +++
 rtl/dsp_reg_mux.sv | 26 ++
 rtl/post_add_acc.sv | 114 +++++++++++
 tb/tb_post_add_acc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP slice definitions: datapath width, OPMODE field layout and X/Z mux encodings.
package dsp_pkg;

  localparam int unsigned DSP_W = 48;
  localparam int unsigned OPM_W = 8;

  localparam int unsigned OPM_X_LSB  = 0;
  localparam int unsigned OPM_Z_LSB  = 2;
  localparam int unsigned OPM_CY_VAL = 4;
  localparam int unsigned OPM_CY_SRC = 5;
  localparam int unsigned OPM_RSVD   = 6;
  localparam int unsigned OPM_SUB    = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_AB   = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

  typedef struct packed {
    logic   sub;
    logic   rsvd;
    logic   cy_src;
    logic   cy_val;
    z_sel_e z_sel;
    x_sel_e x_sel;
  } opmode_t;

endpackage

// File: rtl/dsp_reg_mux.sv
// Optional pipeline register: async-clear flop with clock enable, or a straight wire when bypassed.
module dsp_reg_mux #(
  parameter int unsigned W      = 1,
  parameter bit          BYPASS = 1'b0
) (
  input  logic         CLK,
  input  logic         RSTM,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (BYPASS) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{CLK, RSTM, ce};
      assign q = d;
    end else begin : g_reg
      always_ff @(posedge CLK or posedge RSTM) begin
        if (RSTM)    q <= '0;
        else if (ce) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/post_add_acc.sv
// Post-adder/accumulator: X/Z operand select, 49-bit add/subtract with carry-in, optional P register.
module post_add_acc
  import dsp_pkg::*;
#(
  parameter bit PREG       = 1'b1,
  parameter bit OPMODEREG  = 1'b1,
  parameter bit CARRYINREG = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTM,
  input  logic             CEP,
  input  logic             CEOPMODE,
  input  logic             CECARRYIN,
  input  logic [OPM_W-1:0] OPMODE,
  input  logic [DSP_W-1:0] M_IN,
  input  logic [DSP_W-1:0] ABCAT,
  input  logic [DSP_W-1:0] C,
  input  logic [DSP_W-1:0] PCIN,
  input  logic             CARRYIN,
  output logic [DSP_W-1:0] P,
  output logic [DSP_W-1:0] PCOUT,
  output logic             CARRYOUT
);

  localparam int unsigned SUM_W = DSP_W + 1;

  logic [OPM_W-1:0] opm_raw;
  opmode_t          opm;
  logic             cin_sel_c;
  logic             cin;
  logic [DSP_W-1:0] p_fb;
  logic [DSP_W-1:0] x_c;
  logic [DSP_W-1:0] z_c;
  logic [SUM_W-1:0] sum_c;
  logic             unused_opm;

  dsp_reg_mux #(.W(OPM_W), .BYPASS(!OPMODEREG)) u_opmode_reg (
    .CLK  (CLK),
    .RSTM (RSTM),
    .ce   (CEOPMODE),
    .d    (OPMODE),
    .q    (opm_raw)
  );

  assign opm = opmode_t'(opm_raw);

  // Carry select is taken from the live OPMODE; its own register provides the lag.
  assign cin_sel_c = OPMODE[OPM_CY_SRC] ? CARRYIN : OPMODE[OPM_CY_VAL];

  dsp_reg_mux #(.W(1), .BYPASS(!CARRYINREG)) u_cin_reg (
    .CLK  (CLK),
    .RSTM (RSTM),
    .ce   (CECARRYIN),
    .d    (cin_sel_c),
    .q    (cin)
  );

  assign unused_opm = ^{opm.rsvd, opm.cy_val, opm.cy_src};

  // Without a P register the feedback would be a combinational loop, so it reads as zero.
  generate
    if (PREG) begin : g_fb
      assign p_fb = P;
    end else begin : g_no_fb
      assign p_fb = '0;
    end
  endgenerate

  always_comb begin
    x_c = '0;
    case (opm.x_sel)
      X_M:     x_c = M_IN;
      X_P:     x_c = p_fb;
      X_AB:    x_c = ABCAT;
      default: x_c = '0;
    endcase
  end

  always_comb begin
    z_c = '0;
    case (opm.z_sel)
      Z_PCIN:  z_c = PCIN;
      Z_P:     z_c = p_fb;
      Z_C:     z_c = C;
      default: z_c = '0;
    endcase
  end

  // Top bit is carry on add, borrow on subtract.
  always_comb begin
    sum_c = '0;
    if (opm.sub) sum_c = {1'b0, z_c} - ({1'b0, x_c} + SUM_W'(cin));
    else         sum_c = {1'b0, z_c} + {1'b0, x_c} + SUM_W'(cin);
  end

  dsp_reg_mux #(.W(DSP_W), .BYPASS(!PREG)) u_p_reg (
    .CLK  (CLK),
    .RSTM (RSTM),
    .ce   (CEP),
    .d    (sum_c[DSP_W-1:0]),
    .q    (P)
  );

  dsp_reg_mux #(.W(1), .BYPASS(!PREG)) u_carryout_reg (
    .CLK  (CLK),
    .RSTM (RSTM),
    .ce   (CEP),
    .d    (sum_c[DSP_W]),
    .q    (CARRYOUT)
  );

  assign PCOUT = P;

endmodule

// File: tb/tb_post_add_acc.sv
// Scoreboard bench: registered instance (all regs on) and fully combinational instance share stimulus.
module tb_post_add_acc;

  logic        CLK = 1'b0;
  logic        RSTM = 1'b1;
  logic        CEP = 1'b0, CEOPMODE = 1'b0, CECARRYIN = 1'b0;
  logic [7:0]  OPMODE = '0;
  logic [47:0] M_IN = '0, ABCAT = '0, C = '0, PCIN = '0;
  logic        CARRYIN = 1'b0;

  logic [47:0] p_r, pcout_r, p_c, pcout_c;
  logic        co_r, co_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] p_r;
    logic        co_r;
    logic [47:0] p_c;
    logic        co_c;
  } exp_t;

  exp_t exp_q[$];

  // Reference state of the registered instance
  logic [47:0] m_p;
  logic        m_co;
  logic [7:0]  m_op;
  logic        m_cin;

  always #5 CLK = ~CLK;

  post_add_acc dut_r (
    .CLK(CLK), .RSTM(RSTM), .CEP(CEP), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .OPMODE(OPMODE), .M_IN(M_IN), .ABCAT(ABCAT), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .P(p_r), .PCOUT(pcout_r), .CARRYOUT(co_r)
  );

  post_add_acc #(.PREG(1'b0), .OPMODEREG(1'b0), .CARRYINREG(1'b0)) dut_c (
    .CLK(CLK), .RSTM(RSTM), .CEP(CEP), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .OPMODE(OPMODE), .M_IN(M_IN), .ABCAT(ABCAT), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .P(p_c), .PCOUT(pcout_c), .CARRYOUT(co_c)
  );

  function automatic logic [48:0] ref_alu(input logic [7:0] op, input logic [47:0] m, ab, c,
                                          pc, p, input logic cin);
    logic [48:0] x, z;
    case (op[1:0])
      2'd1:    x = {1'b0, m};
      2'd2:    x = {1'b0, p};
      2'd3:    x = {1'b0, ab};
      default: x = '0;
    endcase
    case (op[3:2])
      2'd1:    z = {1'b0, pc};
      2'd2:    z = {1'b0, p};
      2'd3:    z = {1'b0, c};
      default: z = '0;
    endcase
    if (op[7]) return z - (x + 49'(cin));
    return z + x + 49'(cin);
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return 48'($urandom_range(0, 15));
      default: return v[47:0];
    endcase
  endfunction

  function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  // rst: 0 none, 1 pulse between edges, 2 held across the edge
  task automatic drive(input logic [7:0] op, input logic [47:0] m, ab, c, pc,
                       input logic cy, cep, ceop, cecy, input int rst);
    exp_t        e;
    logic [48:0] r;
    logic        sc;
    OPMODE = op; M_IN = m; ABCAT = ab; C = c; PCIN = pc; CARRYIN = cy;
    CEP = cep; CEOPMODE = ceop; CECARRYIN = cecy;
    sc = op[5] ? cy : op[4];
    if (rst == 2) begin
      RSTM = 1'b1;
      m_p = '0; m_co = 1'b0; m_op = '0; m_cin = 1'b0;
    end else begin
      RSTM = 1'b0;
      if (rst == 1) begin
        RSTM = 1'b1;
        #2;
        RSTM = 1'b0;
        m_p = '0; m_co = 1'b0; m_op = '0; m_cin = 1'b0;
      end
      if (cep) begin
        r = ref_alu(m_op, m, ab, c, pc, m_p, m_cin);
        m_p = r[47:0];
        m_co = r[48];
      end
      if (ceop) m_op = op;
      if (cecy) m_cin = sc;
    end
    r = ref_alu(op, m, ab, c, pc, 48'd0, sc);
    e.p_r = m_p; e.co_r = m_co; e.p_c = r[47:0]; e.co_c = r[48];
    exp_q.push_back(e);
    @(negedge CLK);
    #1;
  endtask

  // Monitor: one expected entry per falling edge
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("p_reg",        p_r,             e.p_r);
      chk("pcout_reg",    pcout_r,         e.p_r);
      chk("carryout_reg", 48'(co_r),       48'(e.co_r));
      chk("p_comb",       p_c,             e.p_c);
      chk("carryout_comb", 48'(co_c),      48'(e.co_c));
      chk("pcout_comb",   pcout_c,         e.p_c);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired queue=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] ones;
    ones = '1;
    m_p = '0; m_co = 1'b0; m_op = '0; m_cin = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      drive(8'($urandom), rnd48(), rnd48(), rnd48(), rnd48(), 1'($urandom), 1'b1, 1'b1, 1'b1, 2);

    // Load accumulate mode, then accumulate 5 per edge
    drive(8'h09, 48'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      drive(8'h09, 48'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    drive(8'h09, 48'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    drive(8'h09, 48'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);

    // Wrap with carry; first edge frozen by CEP=0
    drive(8'h0D, 48'd1, 48'd0, ones, 48'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    drive(8'h0D, 48'd1, 48'd0, ones, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    drive(8'h0D, 48'd1, 48'd0, ones, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Subtract with borrow, mode change lags one edge
    drive(8'h8D, 48'd1, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    drive(8'h8D, 48'd1, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);

    // Dynamic then static carry-in
    drive(8'h23, 48'd0, 48'd7, 48'd0, 48'd0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    drive(8'h23, 48'd0, 48'd7, 48'd0, 48'd0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    drive(8'h13, 48'd0, 48'd7, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    drive(8'h13, 48'd0, 48'd7, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);

    // Comb instance sees P feedback as zero
    drive(8'h0A, 48'd9, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    drive(8'h89, 48'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);

    for (int i = 0; i < 300; i++) begin
      int rs;
      rs = ($urandom_range(0, 49) == 0) ? 1 : 0;
      drive(8'($urandom), rnd48(), rnd48(), rnd48(), rnd48(), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), rs);
    end

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
